// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: runtime configuration and output bundle for pwm_multi_channel.
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int DIV_WIDTH = 8
);
  logic enable;
  logic [WIDTH-1:0] top;
  logic [DIV_WIDTH-1:0] prescale;
  logic centerAligned;
  logic [CHANNELS*WIDTH-1:0] compareValues;
  logic update;
  logic [CHANNELS-1:0] channelEnable;
  logic [CHANNELS-1:0] invert;
  logic [CHANNELS-1:0] pwm;
  logic periodEnd;
  logic [WIDTH-1:0] counterValue;
  modport master (
    output enable, top, prescale, centerAligned, compareValues, update, channelEnable, invert,
    input pwm, periodEnd, counterValue
  );
  modport slave (
    input enable, top, prescale, centerAligned, compareValues, update, channelEnable, invert,
    output pwm, periodEnd, counterValue
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared prescaler and period counter driving CHANNELS compare outputs,
// with top/mode/compares double-buffered and swapped in at period boundaries.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int DIV_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  pwm_multi_channel_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] PONE = DIV_WIDTH'(1);
  logic [DIV_WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] cnt, nxt, top_a, top_s;
  logic [CHANNELS*WIDTH-1:0] cmp_a, cmp_s;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic down, run, ca_a, ca_s, pend, pe, tick, going_down, boundary, load;
  // The first tick after reset or re-enable reloads 0 so it is reported as a period start.
  always_comb begin
    tick = bus.enable && pcnt >= bus.prescale;
    going_down = down || cnt >= top_a;
    nxt = !run ? '0 :
          ca_a ? (going_down ? (cnt == '0 ? '0 : cnt - ONE) : cnt + ONE) :
          (cnt >= top_a ? '0 : cnt + ONE);
    boundary = tick && nxt == '0;
    load = boundary || !bus.enable;
    pwm_d = bus.invert;
    for (int i = 0; i < CHANNELS; i++)
      if (bus.enable && bus.channelEnable[i]) pwm_d[i] = (cnt < cmp_a[i*WIDTH +: WIDTH]) ^ bus.invert[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      cnt <= '0;
      down <= 1'b0;
      run <= 1'b0;
      pe <= 1'b0;
      pwm_q <= '0;
      pend <= 1'b0;
      top_a <= '1;
      top_s <= '1;
      ca_a <= 1'b0;
      ca_s <= 1'b0;
      cmp_a <= '0;
      cmp_s <= '0;
    end else begin
      pcnt <= (tick || !bus.enable) ? '0 : pcnt + PONE;
      if (!bus.enable) begin
        cnt <= '0;
        down <= 1'b0;
        run <= 1'b0;
      end else if (tick) begin
        cnt <= nxt;
        down <= ca_a && going_down && nxt != '0;
        run <= 1'b1;
      end
      pe <= boundary;
      pwm_q <= pwm_d;
      if (bus.update) begin
        top_s <= bus.top;
        ca_s <= bus.centerAligned;
        cmp_s <= bus.compareValues;
      end
      // An update landing on the load cycle bypasses staging and takes effect at once.
      if (load) begin
        top_a <= bus.update ? bus.top : pend ? top_s : top_a;
        ca_a <= bus.update ? bus.centerAligned : pend ? ca_s : ca_a;
        cmp_a <= bus.update ? bus.compareValues : pend ? cmp_s : cmp_a;
      end
      pend <= bus.update ? !load : pend && !load;
    end
  end
  assign bus.pwm = pwm_q;
  assign bus.periodEnd = pe;
  assign bus.counterValue = cnt;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed scenarios plus randomized traffic against a period-phase reference model.
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int W = 8;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W), .DIV_WIDTH(DW)) bus ();
  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .DIV_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int misses = 0;
  int m_pc, m_ph, m_cnt, m_top, m_ca, s_top, s_ca;
  int m_cmp[CH];
  int s_cmp[CH];
  bit m_started, m_pend, m_pe;
  logic [CH-1:0] m_pwm;

  function automatic logic [CH+W:0] got();
    return {bus.pwm, bus.periodEnd, bus.counterValue};
  endfunction

  function automatic logic [CH+W:0] exp_v();
    return {m_pwm, m_pe, W'(m_cnt)};
  endfunction

  function automatic logic [CH*W-1:0] pack(int c0, int c1, int c2, int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic int plen();
    return m_ca != 0 ? (m_top == 0 ? 1 : 2 * m_top) : m_top + 1;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ph = 0; m_cnt = 0; m_started = 0; m_pend = 0; m_pe = 0; m_pwm = '0;
    m_top = 255; m_ca = 0; s_top = 255; s_ca = 0;
    for (int i = 0; i < CH; i++) begin m_cmp[i] = 0; s_cmp[i] = 0; end
  endtask

  // Reference: position within the period (phase) mapped to a counter value by the mode rules.
  task automatic step();
    logic [CH-1:0] pw;
    bit tick, load;
    for (int i = 0; i < CH; i++)
      pw[i] = (bus.enable && bus.channelEnable[i]) ? ((m_cnt < m_cmp[i]) ^ bus.invert[i]) : bus.invert[i];
    m_pe = 0;
    load = 0;
    if (!bus.enable) begin
      m_pc = 0; m_started = 0; m_ph = 0; load = 1;
    end else begin
      tick = m_pc >= int'(bus.prescale);
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) begin
        m_ph = m_started ? (m_ph + 1) % plen() : 0;
        m_started = 1;
        m_pe = (m_ph == 0);
        load = m_pe;
      end
    end
    if (load && bus.update) begin
      m_top = bus.top; m_ca = bus.centerAligned;
      for (int i = 0; i < CH; i++) m_cmp[i] = bus.compareValues[i*W +: W];
    end else if (load && m_pend) begin
      m_top = s_top; m_ca = s_ca;
      for (int i = 0; i < CH; i++) m_cmp[i] = s_cmp[i];
    end
    if (load) m_pend = 0;
    if (bus.update) begin
      s_top = bus.top; s_ca = bus.centerAligned;
      for (int i = 0; i < CH; i++) s_cmp[i] = bus.compareValues[i*W +: W];
      m_pend = !load;
    end
    m_cnt = (m_ca == 0 || m_ph <= m_top) ? m_ph : 2 * m_top - m_ph;
    m_pwm = pw;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(int top, int ca, int c0, int c1, int c2, int c3, int pre);
    bus.enable = 1'b0;
    bus.top = W'(top);
    bus.centerAligned = ca[0];
    bus.compareValues = pack(c0, c1, c2, c3);
    bus.prescale = DW'(pre);
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    bus.enable = 1'b1;
  endtask

  task automatic wait_pe(string name, int bound);
    int n = 0;
    while (!bus.periodEnd && n < bound) begin step(); n++; end
    vectors++;
    if (bus.periodEnd !== 1'b1) begin
      misses++;
      $display("FAIL %s: no periodEnd within %0d clocks", name, bound);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (got() !== '0) begin misses++; $display("FAIL reset_initial: got=%h expected=0", got()); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    bus.channelEnable = '1;
    bus.invert = '0;
    setup(9, 0, 5, 0, 0, 0, 0);
    repeat (20) begin
      step(); vectors++;
      if (got() !== exp_v()) begin misses++; $display("FAIL reset_run t=%0t got=%h expected=%h", $time, got(), exp_v()); end
    end
    while (bus.pwm[0] !== 1'b1 && n < 12) begin step(); n++; end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (got() !== '0) begin misses++; $display("FAIL reset_async: got=%h expected=0", got()); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (20) begin
      step(); vectors++;
      if (got() !== exp_v() || bus.pwm[0] !== 1'b0) begin
        misses++; $display("FAIL reset_cmp_cleared t=%0t got=%h expected=%h", $time, got(), exp_v());
      end
    end
  endtask

  task automatic test_edge();
    int h0 = 0, h1 = 0, pes = 0;
    setup(9, 0, 3, 9, 0, 10, 0);
    wait_pe("edge_start", 15);
    for (int k = 1; k <= 10; k++) begin
      step(); vectors++;
      if (got() !== exp_v()) begin misses++; $display("FAIL edge_model t=%0t got=%h expected=%h", $time, got(), exp_v()); end
      h0 += int'(bus.pwm[0]); h1 += int'(bus.pwm[1]); pes += int'(bus.periodEnd);
    end
    vectors++;
    if (h0 != 3 || h1 != 9) begin misses++; $display("FAIL edge_duty: ch0=%0d ch1=%0d expected 3 and 9", h0, h1); end
    vectors++;
    if (pes != 1 || bus.periodEnd !== 1'b1) begin misses++; $display("FAIL edge_period: pulses=%0d expected 1 on clock 10", pes); end
  endtask

  task automatic test_extremes();
    setup(9, 0, 0, 10, 0, 10, 0);
    bus.channelEnable = 4'b1011;
    for (int inv = 0; inv < 2; inv++) begin
      logic [CH-1:0] want;
      bus.invert = inv != 0 ? '1 : '0;
      want = inv != 0 ? 4'b0101 : 4'b1010;
      repeat (12) begin
        step(); vectors++;
        if (bus.pwm !== want || got() !== exp_v()) begin
          misses++; $display("FAIL extremes inv=%0d: pwm=%b expected=%b", inv, bus.pwm, want);
        end
      end
    end
    bus.channelEnable = '1;
    bus.invert = '0;
  endtask

  task automatic test_mid_update();
    int hi[3] = '{0, 0, 0};
    int want[3] = '{3, 5, 2};
    setup(9, 0, 3, 0, 0, 0, 0);
    wait_pe("update_start", 15);
    for (int p = 0; p < 3; p++)
      for (int k = 1; k <= 10; k++) begin
        bus.update = (p == 0 && (k == 5 || k == 7)) || (p == 1 && k == 10);
        bus.compareValues = pack(p == 1 ? 2 : (k == 5 ? 7 : 5), 0, 0, 0);
        step(); vectors++;
        if (got() !== exp_v()) begin misses++; $display("FAIL update_model t=%0t got=%h expected=%h", $time, got(), exp_v()); end
        hi[p] += int'(bus.pwm[0]);
      end
    bus.update = 1'b0;
    for (int p = 0; p < 3; p++) begin
      vectors++;
      if (hi[p] != want[p]) begin misses++; $display("FAIL update_period%0d: high=%0d expected=%0d", p, hi[p], want[p]); end
    end
  endtask

  task automatic test_center();
    int seq[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1};
    int hi = 0;
    setup(4, 1, 2, 2, 2, 2, 1);
    wait_pe("center_start", 40);
    for (int k = 1; k <= 16; k++) begin
      step(); vectors++;
      if (got() !== exp_v() || int'(bus.counterValue) != seq[k % 16] || bus.periodEnd !== (k == 16)) begin
        misses++; $display("FAIL center k=%0d: cnt=%0d pe=%b expected cnt=%0d pe=%b", k, bus.counterValue, bus.periodEnd, seq[k % 16], k == 16);
      end
      hi += int'(bus.pwm[0]);
    end
    vectors++;
    if (hi != 6) begin misses++; $display("FAIL center_duty: high=%0d expected=6", hi); end
  endtask

  task automatic test_disable();
    int hi = 0;
    setup(9, 0, 3, 0, 0, 0, 0);
    bus.invert = 4'b0110;
    wait_pe("disable_start", 15);
    repeat (3) step();
    bus.compareValues = pack(6, 0, 0, 0);
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    bus.enable = 1'b0;
    repeat (5) begin
      step(); vectors++;
      if (bus.counterValue !== '0 || bus.pwm !== 4'b0110 || got() !== exp_v()) begin
        misses++; $display("FAIL disable_idle: cnt=%0d pwm=%b expected cnt=0 pwm=0110", bus.counterValue, bus.pwm);
      end
    end
    bus.prescale = 8'd2;
    bus.enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(); vectors++;
      if (bus.periodEnd !== (k == 3)) begin misses++; $display("FAIL disable_restart k=%0d: pe=%b expected=%b", k, bus.periodEnd, k == 3); end
    end
    repeat (30) begin
      step(); vectors++;
      if (got() !== exp_v()) begin misses++; $display("FAIL disable_model t=%0t got=%h expected=%h", $time, got(), exp_v()); end
      hi += int'(bus.pwm[0]);
    end
    vectors++;
    if (hi != 18) begin misses++; $display("FAIL disable_newcmp: high=%0d expected=18", hi); end
    bus.invert = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bus.update = $urandom_range(0, 7) == 0;
      if (bus.update) begin
        bus.top = W'($urandom_range(0, 12));
        bus.centerAligned = 1'($urandom_range(0, 1));
        bus.compareValues = pack($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14));
      end
      if ($urandom_range(0, 49) == 0) bus.prescale = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin bus.invert = CH'($urandom); bus.channelEnable = CH'($urandom); end
      bus.enable = bus.enable ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 3) == 0);
      step(); vectors++;
      if (got() !== exp_v()) begin misses++; $display("FAIL random n=%0d got=%h expected=%h", n, got(), exp_v()); end
    end
    bus.update = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0; bus.top = '0; bus.prescale = '0; bus.centerAligned = 1'b0;
    bus.compareValues = '0; bus.update = 1'b0; bus.channelEnable = '0; bus.invert = '0;
    model_reset();
    test_reset();
    test_edge();
    test_extremes();
    test_mid_update();
    test_center();
    test_disable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator and the parametrised successor to the single-channel PWM utility. One shared prescaler and period counter drive `CHANNELS` independent compare outputs. Period, compare values and counting mode are programmable at runtime and double-buffered so changes apply only at period boundaries. Edge-aligned and center-aligned modes are supported. The block sits in the Utility library and is instantiated by peripheral wrappers that expose its inputs as Wishbone registers.

## Interface
- `CHANNELS`, 4, number of PWM outputs.
- `WIDTH`, 16, width of the counter, `top` and each compare value.
- `DIV_WIDTH`, 8, width of the prescale input.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: global run. When low, the prescaler and counter are held at 0.
- `top` in `WIDTH`: period top value (staged).
- `prescale` in `DIV_WIDTH`: counter advances once every `prescale+1` clocks. Live, not staged.
- `centerAligned` in 1: 0 selects edge-aligned, 1 selects up/down counting (staged).
- `compareValues` in `CHANNELS*WIDTH`: channel i occupies `[i*WIDTH +: WIDTH]` (staged).
- `update` in 1: one-clock strobe that captures all staged inputs.
- `channelEnable` in `CHANNELS`: live per-channel enable.
- `invert` in `CHANNELS`: live per-channel output polarity.
- `pwm` out `CHANNELS`: registered PWM outputs.
- `periodEnd` out 1: one-clock pulse at each period start.
- `counterValue` out `WIDTH`: current counter value.

## Operation
- **Reset** (`rst` low, asynchronous):
  - `counterValue`, prescaler, `pwm`, `periodEnd` and the pending flag go to 0.
  - Active compares go to 0, active `top` to all-ones, active mode to edge.
  - Staging registers are cleared to the same values.
- **Prescaler**: a tick is generated when prescaleCount >= `prescale`, and the count then returns to 0. With `prescale=0` there is a tick every clock. Using >= means a runtime decrease of `prescale` never stalls the prescaler.
- **Edge mode**:
  - Counter runs 0..top and wraps to 0.
  - Period = (top+1)*(prescale+1) clocks.
- **Center mode**:
  - Counter runs 0,1..top, top-1..1, then 0.
  - Period = 2*top ticks.
  - With top=0 the counter stays at 0 and every tick is a period start.
- **Shadowing**:
  - `update` copies `top`, `centerAligned` and `compareValues` into staging and sets pending. A later `update` in the same period overwrites staging (last wins).
  - At a period boundary (a tick that loads counter=0) with pending set, staging moves to the active registers and pending clears.
  - If `update` coincides with a boundary tick, the new inputs go straight to the active registers and pending clears.
- **Per-channel output**:
  - raw = counter < activeCompare[i] (unsigned).
  - `pwm[i]` = channelEnable[i] ? raw ^ invert[i] : invert[i].
  - A compare of 0 gives constant inactive.
  - A compare > top gives constant active in edge mode, so top+1 is 100%.
  - In center mode, a compare > top is also constant active.
- **enable low**:
  - Counter and prescaler are forced to 0.
  - A pending update is applied on the next clock.
  - `pwm[i]` = invert[i] (idle level).
  - On re-enable, counting starts at 0 and `periodEnd` pulses with the first tick-loaded 0.

## Timing
- `counterValue` is registered and changes on a tick edge.
- `pwm` is registered from the current counter and active compare, so it lags `counterValue` by 1 clock.
- `periodEnd` is high for exactly 1 clock, in the same cycle `counterValue` first shows 0 of a new period. It is aligned with the active-register load.
- Staged values affect `pwm` starting 1 clock after the `periodEnd` that loaded them.
- `invert` and `channelEnable` affect `pwm` 1 clock after they change (no shadowing).
- Reset deassertion is synchronised by the instantiating wrapper. The first tick occurs `prescale+1` clocks after `rst` and `enable` are both high.

## Test plan
1. **Reset mid-run.** Drive `rst` low while counting with pwm high. Required: `pwm`=0, `counterValue`=0 and `periodEnd`=0 immediately, without a clock edge. Active compare reads 0 after release.
2. **Edge mode.** Settings: CHANNELS=4, WIDTH=8, prescale=0, top=9, compare ch0=3, ch1=9. Required:
   - `pwm[0]` high 3 of every 10 clocks.
   - `pwm[1]` high 9 of every 10 clocks.
   - `periodEnd` every 10 clocks.
   - `pwm` lags counter by 1 clock.
3. **Extremes and polarity.** Set compare 0, then 10 (top+1), each with invert=0 and invert=1. Required:
   - Constant 0 / 1 with invert=0, and the complements with invert=1.
   - `channelEnable`=0 gives the constant invert level.
4. **Mid-period update.** At counter=4, `update` changes ch0 3→7; a second `update` at counter=6 writes 5. Required: the current period stays at 3 high; the next period is 5 high. An `update` on the boundary tick applies in that period.
5. **Center mode.** Settings: top=4, prescale=1, compare=2. Required:
   - Counter sequence 0,1,2,3,4,3,2,1, each value held 2 clocks.
   - Period 16 clocks; `pwm` high 6 clocks centred on counter 0.
   - `periodEnd` every 16 clocks.
6. **Disable.** Drop `enable` mid-period with a pending update, then re-enable. Required:
   - Counter at 0 and `pwm` = invert while disabled.
   - The new compare is active on re-enable.
   - `periodEnd` pulses `prescale+1` clocks after re-enable.
